// File: rtl/btn_keyboard.sv
// Debounced DE0 pushbutton/switch keyboard presenting a Hack-style keyboard register.
// One key code is latched per press; the register reads zero while no key is held.
module btn_keyboard #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic [14:0] KBD_ADDR        = 15'h6000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  btn,
  input  logic [9:0]  sw,
  input  logic [14:0] addressM,
  output logic [15:0] kbd_data,
  output logic        kbd_sel,
  output logic        key_down,
  output logic [7:0]  press_count
);

  localparam int unsigned NumBits = 13;
  localparam int unsigned CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  // Buttons idle high (released), switches idle low.
  localparam logic [NumBits-1:0] RstVal = {10'b0, 3'b111};

  typedef enum logic [0:0] {StIdle, StDown} state_e;

  logic [NumBits-1:0] raw;
  logic [NumBits-1:0] sync1_q;
  logic [NumBits-1:0] sync2_q;
  logic [NumBits-1:0] stable_q;

  assign raw = {sw, btn};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= RstVal;
      sync2_q <= RstVal;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < NumBits; i++) begin : g_debounce
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        stable_q[i] <= RstVal[i];
        cnt_q       <= '0;
      end else if (sync2_q[i] == stable_q[i]) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        // Counter would reach DEBOUNCE_CYCLES on this edge: accept the change.
        stable_q[i] <= sync2_q[i];
        cnt_q       <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  logic [2:0] db_btn;
  logic [9:0] db_sw;
  logic [2:0] pressed;

  assign db_btn  = stable_q[2:0];
  assign db_sw   = stable_q[12:3];
  assign pressed = ~db_btn;

  state_e      state_q, state_d;
  logic [15:0] kbd_data_q, kbd_data_d;
  logic [7:0]  count_q, count_d;
  logic        key_down_q;

  always_comb begin
    state_d    = state_q;
    kbd_data_d = kbd_data_q;
    count_d    = count_q;
    unique case (state_q)
      StIdle: begin
        kbd_data_d = 16'd0;
        if (|pressed) begin
          state_d = StDown;
          count_d = count_q + 8'd1;
          if (pressed[2]) begin
            kbd_data_d = 16'd129;
          end else if (pressed[1]) begin
            kbd_data_d = 16'd128;
          end else begin
            kbd_data_d = {6'b0, db_sw};
          end
        end
      end
      StDown: begin
        if (&db_btn) begin
          state_d    = StIdle;
          kbd_data_d = 16'd0;
        end
      end
      default: begin
        state_d    = StIdle;
        kbd_data_d = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      kbd_data_q <= 16'd0;
      count_q    <= 8'd0;
      key_down_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kbd_data_q <= kbd_data_d;
      count_q    <= count_d;
      key_down_q <= (state_d == StDown);
    end
  end

  assign kbd_data    = kbd_data_q;
  assign key_down    = key_down_q;
  assign press_count = count_q;
  assign kbd_sel     = (addressM == KBD_ADDR);

endmodule

// File: tb/tb_btn_keyboard.sv
// Directed bench for btn_keyboard with DEBOUNCE_CYCLES = 4 (raw-to-output latency 7 clocks).
module tb_btn_keyboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  btn;
  logic [9:0]  sw;
  logic [14:0] addressM;
  logic [15:0] kbd_data;
  logic        kbd_sel;
  logic        key_down;
  logic [7:0]  press_count;

  int checks   = 0;
  int failures = 0;

  btn_keyboard #(
    .DEBOUNCE_CYCLES(4),
    .KBD_ADDR       (15'h6000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .sw         (sw),
    .addressM   (addressM),
    .kbd_data   (kbd_data),
    .kbd_sel    (kbd_sel),
    .key_down   (key_down),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b1;
    btn      = 3'b111;
    sw       = 10'h000;
    addressM = 15'h0000;
    tick(3);
    check("rst_kbd_data", kbd_data, 16'd0);
    check("rst_key_down", {15'd0, key_down}, 16'd0);
    check("rst_count", {8'd0, press_count}, 16'd0);
    reset = 1'b0;
    tick(2);

    // Address decode is combinational.
    addressM = 15'h6000;
    #1;
    check("sel_hit", {15'd0, kbd_sel}, 16'd1);
    addressM = 15'h5FFF;
    #1;
    check("sel_miss", {15'd0, kbd_sel}, 16'd0);

    // Glitch of 3 clocks on btn[1] must be rejected.
    btn = 3'b101;
    tick(3);
    btn = 3'b111;
    tick(12);
    check("glitch_kbd_data", kbd_data, 16'd0);
    check("glitch_count", {8'd0, press_count}, 16'd0);
    check("glitch_key_down", {15'd0, key_down}, 16'd0);

    // btn[0] press with sw = 0x041: exact 7-clock latency.
    sw  = 10'h041;
    btn = 3'b110;
    tick(6);
    check("b0_early", kbd_data, 16'd0);
    tick(1);
    check("b0_kbd_data", kbd_data, 16'h0041);
    check("b0_key_down", {15'd0, key_down}, 16'd1);
    check("b0_count", {8'd0, press_count}, 16'd1);
    btn = 3'b111;
    tick(6);
    check("b0_rel_early", kbd_data, 16'h0041);
    tick(1);
    check("b0_rel_kbd_data", kbd_data, 16'd0);
    check("b0_rel_key_down", {15'd0, key_down}, 16'd0);

    // btn[2] + btn[0] together: backspace wins; later changes ignored while held.
    btn = 3'b010;
    tick(7);
    check("bs_kbd_data", kbd_data, 16'd129);
    check("bs_count", {8'd0, press_count}, 16'd2);
    sw  = 10'h3FF;
    btn = 3'b000;
    tick(12);
    check("bs_hold_kbd_data", kbd_data, 16'd129);
    check("bs_hold_count", {8'd0, press_count}, 16'd2);
    btn = 3'b111;
    tick(6);
    check("bs_rel_early", kbd_data, 16'd129);
    tick(1);
    check("bs_rel_kbd_data", kbd_data, 16'd0);
    check("bs_rel_key_down", {15'd0, key_down}, 16'd0);

    // 256 clean btn[1] presses: count wraps through 0 and returns to its start.
    for (int i = 0; i < 256; i++) begin
      btn = 3'b101;
      tick(8);
      if (i == 0) check("nl_kbd_data", kbd_data, 16'd128);
      if (i == 253) check("wrap_zero", {8'd0, press_count}, 16'd0);
      btn = 3'b111;
      tick(8);
    end
    check("wrap_count", {8'd0, press_count}, 16'd2);

    // Reset while held in DOWN, button kept held afterwards.
    sw  = 10'h155;
    btn = 3'b110;
    tick(7);
    check("pre_rst_kbd_data", kbd_data, 16'h0155);
    check("pre_rst_count", {8'd0, press_count}, 16'd3);
    reset = 1'b1;
    tick(1);
    check("rst_down_kbd_data", kbd_data, 16'd0);
    check("rst_down_key_down", {15'd0, key_down}, 16'd0);
    check("rst_down_count", {8'd0, press_count}, 16'd0);
    tick(1);
    reset = 1'b0;
    tick(6);
    check("post_rst_early", kbd_data, 16'd0);
    tick(1);
    check("post_rst_kbd_data", kbd_data, 16'h0155);
    check("post_rst_count", {8'd0, press_count}, 16'd1);
    check("post_rst_key_down", {15'd0, key_down}, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
